// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: three-lane horizontal position plus a tick-paced jump
// sequencer for the player sprite. All outputs are registered and feed the
// renderer and collision logic directly.
module player_motion_ctrl #(
    parameter int TICK_DIV    = 1000000, // clk cycles per motion tick (>=2)
    parameter int LANE_MIN_X  = 140,     // x of lane 0
    parameter int LANE_STEP   = 120,     // x distance between lanes
    parameter int GROUND_Y    = 350,     // y when standing
    parameter int JUMP_HEIGHT = 40,      // pixels risen at apex (1..GROUND_Y)
    parameter int HANG_TICKS  = 8        // ticks held at apex (>=1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left,
    input  logic       right,
    input  logic       jump,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic [1:0] lane,
    output logic       airborne,
    output logic       jump_pending
);

    localparam int CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HANG_W = (HANG_TICKS > 1) ? $clog2(HANG_TICKS) : 1;

    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [HANG_W-1:0] HANG_LAST = HANG_W'(HANG_TICKS - 1);

    localparam logic [9:0] X_LANE0 = 10'(LANE_MIN_X);
    localparam logic [9:0] X_LANE1 = 10'(LANE_MIN_X + LANE_STEP);
    localparam logic [9:0] X_LANE2 = 10'(LANE_MIN_X + 2 * LANE_STEP);

    localparam logic [8:0] Y_GROUND    = 9'(GROUND_Y);
    localparam logic [8:0] Y_GROUND_M1 = 9'(GROUND_Y - 1);
    // y one pixel below the apex: the RISE step taken from here reaches it
    localparam logic [8:0] Y_APEX_P1   = 9'(GROUND_Y - JUMP_HEIGHT + 1);

    typedef enum logic [1:0] {
        GROUND,
        RISE,
        HANG,
        FALL
    } jump_state_t;

    jump_state_t       state, state_nxt;
    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic [HANG_W-1:0] hang_cnt, hang_cnt_nxt;
    logic [1:0]        lane_nxt;
    logic [9:0]        x_nxt;
    logic [8:0]        y_nxt;
    logic              pending_nxt;

    assign tick = (tick_cnt == TICK_LAST);

    // Free-running motion tick divider, wraps at TICK_DIV-1.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // Lane selection: a lone left/right pulse moves one lane within 0..2;
    // x is derived from the next lane so both update on the same edge.
    // NOTE: every signal assigned in an always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        lane_nxt = lane;
        if (left && !right && lane != 2'd0) begin
            lane_nxt = lane - 2'd1;
        end else if (right && !left && lane != 2'd2) begin
            lane_nxt = lane + 2'd1;
        end

        unique case (lane_nxt)
            2'd0:    x_nxt = X_LANE0;
            2'd2:    x_nxt = X_LANE2;
            default: x_nxt = X_LANE1;
        endcase
    end

    // Jump sequencer next-state and y arithmetic, plus the one-deep jump buffer.
    always_comb begin
        state_nxt    = state;
        y_nxt        = y;
        hang_cnt_nxt = hang_cnt;
        pending_nxt  = jump_pending;

        unique case (state)
            GROUND: begin
                // Launch does not wait for a tick; a buffered request counts too
                y_nxt = Y_GROUND;
                if (jump || jump_pending) begin
                    state_nxt   = RISE;
                    pending_nxt = 1'b0;
                end
            end
            RISE: begin
                if (tick) begin
                    y_nxt = y - 9'd1;
                    if (y == Y_APEX_P1) begin
                        state_nxt    = HANG;
                        hang_cnt_nxt = '0;
                    end
                end
            end
            HANG: begin
                if (tick) begin
                    if (hang_cnt == HANG_LAST) begin
                        state_nxt = FALL;
                    end else begin
                        hang_cnt_nxt = hang_cnt + HANG_W'(1);
                    end
                end
            end
            FALL: begin
                if (tick) begin
                    y_nxt = y + 9'd1;
                    if (y == Y_GROUND_M1) begin
                        state_nxt = GROUND;
                    end
                end
            end
        endcase

        // A press while airborne is remembered once; extra presses are dropped
        if (state != GROUND && jump) begin
            pending_nxt = 1'b1;
        end
    end

    // State and output registers; reset returns the sprite to lane 1 on ground.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= GROUND;
            hang_cnt     <= '0;
            lane         <= 2'd1;
            x            <= X_LANE1;
            y            <= Y_GROUND;
            airborne     <= 1'b0;
            jump_pending <= 1'b0;
        end else begin
            state        <= state_nxt;
            hang_cnt     <= hang_cnt_nxt;
            lane         <= lane_nxt;
            x            <= x_nxt;
            y            <= y_nxt;
            airborne     <= (state_nxt != GROUND);
            jump_pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: directed test of lane stepping, jump timing, jump
// buffering and mid-jump reset with TICK_DIV=4, JUMP_HEIGHT=4, HANG_TICKS=2.
module tb_player_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       left, right, jump;
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] lane;
    logic       airborne;
    logic       jump_pending;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected y after motion ticks 1..10 of a jump (height 4, hang 2)
    int exp_y [10] = '{349, 348, 347, 346, 346, 346, 347, 348, 349, 350};
    int exp_x;
    int exp_lane;
    int exp_pend;

    player_motion_ctrl #(
        .TICK_DIV   (4),
        .LANE_MIN_X (140),
        .LANE_STEP  (120),
        .GROUND_Y   (350),
        .JUMP_HEIGHT(4),
        .HANG_TICKS (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .left        (left),
        .right       (right),
        .jump        (jump),
        .x           (x),
        .y           (y),
        .lane        (lane),
        .airborne    (airborne),
        .jump_pending(jump_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Advance one clock edge and settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Apply one single-cycle pulse pattern and advance one edge
    task automatic pulse(input logic l, input logic r, input logic j);
        left  = l;
        right = r;
        jump  = j;
        step();
        left  = 1'b0;
        right = 1'b0;
        jump  = 1'b0;
    endtask

    // One motion tick period of a jump: 'holds' non-tick edges where y must
    // hold, then the tick edge producing exp_y[k]. Optional pulses go on the
    // first hold edge; x/lane/pending expectations are set by the caller.
    task automatic tick_span(input int k, input int holds,
                             input logic pl, input logic pr, input logic pj);
        int prev_y;
        prev_y = (k == 0) ? 350 : exp_y[k-1];
        for (int i = 0; i < holds; i++) begin
            if (i == 0) pulse(pl, pr, pj);
            else        pulse(1'b0, 1'b0, 1'b0);
            check("y_hold", y, prev_y);
            check("x", x, exp_x);
            check("lane", lane, exp_lane);
            check("pending", jump_pending, exp_pend);
            check("airborne", airborne, 1);
        end
        step();
        check("y_tick", y, exp_y[k]);
        check("x_tick", x, exp_x);
        check("pending_tick", jump_pending, exp_pend);
        check("airborne_tick", airborne, (k == 9) ? 0 : 1);
    endtask

    task automatic idle_ground(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("idle_y", y, 350);
            check("idle_airborne", airborne, 0);
            check("idle_pending", jump_pending, 0);
            check("idle_x", x, exp_x);
        end
    endtask

    initial begin
        rst   = 1'b1;
        left  = 1'b0;
        right = 1'b0;
        jump  = 1'b0;
        step();
        step();
        // Release: the last edge with rst high is cycle 0 of the tick divider
        rst = 1'b0;
        cyc = 0;
        check("rst_x", x, 260);
        check("rst_y", y, 350);
        check("rst_lane", lane, 1);
        check("rst_airborne", airborne, 0);
        check("rst_pending", jump_pending, 0);
        exp_x    = 260;
        exp_lane = 1;
        exp_pend = 0;

        // Jump A from ground right after reset: launches on edge 1, first
        // tick lands on edge 4.
        pulse(1'b0, 1'b0, 1'b1);
        check("launch_airborne", airborne, 1);
        check("launch_y", y, 350);
        tick_span(0, 2, 1'b0, 1'b0, 1'b0);
        check("first_tick_cycle", cyc, 4);
        for (int k = 1; k < 10; k++) tick_span(k, 3, 1'b0, 1'b0, 1'b0);
        check("landed_cycle", cyc, 40);

        // Lane stepping and edge cases
        pulse(1'b1, 1'b0, 1'b0);
        check("left1_x", x, 140);
        check("left1_lane", lane, 0);
        pulse(1'b1, 1'b0, 1'b0);
        check("left2_x", x, 140);
        pulse(1'b1, 1'b0, 1'b0);
        check("left3_x", x, 140);
        check("left3_lane", lane, 0);
        pulse(1'b0, 1'b1, 1'b0);
        check("right1_x", x, 260);
        pulse(1'b0, 1'b1, 1'b0);
        check("right2_x", x, 380);
        check("right2_lane", lane, 2);
        pulse(1'b1, 1'b1, 1'b0);
        check("both_x", x, 380);
        pulse(1'b0, 1'b1, 1'b0);
        check("right_edge_x", x, 380);
        check("right_edge_lane", lane, 2);
        pulse(1'b1, 1'b0, 1'b0);
        check("back_left_x", x, 260);
        exp_x    = 260;
        exp_lane = 1;

        // Jump B: aligned so the launch edge is one past a tick edge
        while (cyc % 4 != 0) step();
        pulse(1'b0, 1'b0, 1'b1);
        check("b_launch_airborne", airborne, 1);
        tick_span(0, 2, 1'b0, 1'b0, 1'b0);
        exp_pend = 1;
        tick_span(1, 3, 1'b0, 1'b0, 1'b1);   // press during RISE
        tick_span(2, 3, 1'b0, 1'b0, 1'b0);
        tick_span(3, 3, 1'b0, 1'b0, 1'b0);
        tick_span(4, 3, 1'b0, 1'b0, 1'b1);   // press during HANG, dropped
        for (int k = 5; k < 10; k++) tick_span(k, 3, 1'b0, 1'b0, 1'b0);
        // Landed: one cycle in GROUND with the buffered request still held
        check("b_ground_pending", jump_pending, 1);
        check("b_ground_y", y, 350);
        step();
        check("b_relaunch_airborne", airborne, 1);
        check("b_relaunch_pending", jump_pending, 0);
        check("b_relaunch_y", y, 350);
        exp_pend = 0;

        // Buffered jump runs; a right press during FALL moves x next edge
        tick_span(0, 2, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 7; k++) tick_span(k, 3, 1'b0, 1'b0, 1'b0);
        exp_x    = 380;
        exp_lane = 2;
        tick_span(7, 3, 1'b0, 1'b1, 1'b0);
        tick_span(8, 3, 1'b0, 1'b0, 1'b0);
        tick_span(9, 3, 1'b0, 1'b0, 1'b0);
        idle_ground(8);

        // Jump C: reset during HANG with a buffered request outstanding
        while (cyc % 4 != 0) step();
        pulse(1'b0, 1'b0, 1'b1);
        tick_span(0, 2, 1'b0, 1'b0, 1'b0);
        exp_pend = 1;
        tick_span(1, 3, 1'b0, 1'b0, 1'b1);
        tick_span(2, 3, 1'b0, 1'b0, 1'b0);
        tick_span(3, 3, 1'b0, 1'b0, 1'b0);
        step();
        check("c_hang_y", y, 346);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
        check("c_rst_y", y, 350);
        check("c_rst_x", x, 260);
        check("c_rst_lane", lane, 1);
        check("c_rst_airborne", airborne, 0);
        check("c_rst_pending", jump_pending, 0);
        exp_x = 260;
        idle_ground(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
Sequencer for the player sprite's position. It takes debounced single-cycle button pulses and runs a lane-change state machine for x (three fixed lanes). It also runs a jump state machine for y (ground, rise, hang, fall), advanced by an internal tick divider. Outputs feed the renderer and the collision logic directly.

Parameters:
TICK_DIV, 1000000, clk cycles per motion tick (>=2)
LANE_MIN_X, 140, x of lane 0
LANE_STEP, 120, x distance between lanes
GROUND_Y, 350, y when standing
JUMP_HEIGHT, 40, pixels risen at jump apex (1..GROUND_Y)
HANG_TICKS, 8, ticks held at apex (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
left  in  1  debounced one-cycle pulse: move one lane left
right  in  1  debounced one-cycle pulse: move one lane right
jump  in  1  debounced one-cycle pulse: start jump
x  out  10  player x, registered
y  out  9  player y, registered
lane  out  2  current lane 0..2
airborne  out  1  high when the jump FSM is not in GROUND
jump_pending  out  1  one buffered jump request waiting

Behaviour:
- All state is on posedge clk. rst is synchronous and active-high, and overrides everything.
- Reset values: lane=1, x=LANE_MIN_X+LANE_STEP (260), y=GROUND_Y, FSM=GROUND, airborne=0, jump_pending=0, tick counter=0, hang counter=0.
- Tick divider: counter runs 0..TICK_DIV-1 and wraps. tick=1 for one cycle when the counter equals TICK_DIV-1. First tick comes TICK_DIV cycles after reset release.
- Lane logic runs every cycle, independent of the jump FSM:
  - left alone with lane>0: lane-1.
  - right alone with lane<2: lane+1.
  - left at lane 0 or right at lane 2: ignored.
  - left and right in the same cycle: ignored.
  - x updates in the same clock edge as lane, so x = LANE_MIN_X + lane*LANE_STEP with no extra latency. Lane changes are allowed while airborne.
- Jump FSM states: GROUND, RISE, HANG, FALL.
  - GROUND:
    - jump pulse or jump_pending=1 -> RISE next cycle; clear jump_pending.
    - y is held at GROUND_Y.
  - RISE: on tick, y-1. When the decremented y equals GROUND_Y-JUMP_HEIGHT -> HANG with hang counter=0.
  - HANG: on tick, hang counter+1. On the tick where the counter equals HANG_TICKS-1 -> FALL. y is held.
  - FALL: on tick, y+1. When the incremented y equals GROUND_Y -> GROUND.
  - Non-tick cycles hold y and state, except the GROUND->RISE exit, which does not wait for a tick.
- Jump buffering:
  - jump pulse while airborne sets jump_pending; further pulses while it is set are dropped (depth 1).
  - A pending jump launches on the first cycle back in GROUND, so one clock is spent in GROUND.
  - jump pulse in GROUND is consumed immediately and does not set pending.
- airborne = (state != GROUND), registered with the state.
- Arithmetic: y never goes above GROUND_Y or below GROUND_Y-JUMP_HEIGHT. Full jump length is 2*JUMP_HEIGHT+HANG_TICKS ticks plus up to one partial tick period.
- Reset mid-jump: the next cycle shows y=GROUND_Y, GROUND, pending cleared, lane 1.
- Inputs are assumed to be single-cycle pulses. A level held high acts as a pulse every cycle: repeated lane steps up to the edge lane, and one pending jump.

Test Plan:
- TICK_DIV=4, release rst -> x=260, y=350, lane=1, airborne=0; first tick on cycle 4.
- left pulse, left pulse, left pulse -> lane 0, x=140, third pulse ignored. Then right pulse twice -> x=380. Then left+right same cycle -> x stays 380.
- JUMP_HEIGHT=4, HANG_TICKS=2, jump pulse from ground -> airborne=1 next cycle; y steps 349,348,347,346 on ticks 1-4; holds 346 for 2 ticks; steps 347..350 on the next 4 ticks; airborne=0 after y=350.
- Jump pulse during RISE, second pulse during HANG -> jump_pending=1 once; after landing, one GROUND cycle, then RISE with pending=0; only one extra jump occurs.
- Right pulse during FALL -> x changes next cycle to the new lane, y sequence unaffected.
- rst asserted during HANG (y=346) -> next cycle y=350, x=260, airborne=0, jump_pending=0; no further motion without new pulses.
